// File: rtl/spn_decrypt_core.sv
// Iterative 16-bit SPN block decryptor, one inverse round per clock.
// Inverts the forward cipher: R-1 rounds of P(S(s ^ K_r)), then S(s ^ K_(R-1)) ^ K_R.
module spn_decrypt_core #(
    parameter int unsigned ROUNDS = 4,
    localparam int unsigned KEY_W = 16 + 4 * ROUNDS
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [15:0]      in_data,
    input  logic [KEY_W-1:0] in_key,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [15:0]      out_data,
    output logic             busy
);

    localparam int unsigned CNT_W = $clog2(ROUNDS + 2);

    typedef enum logic [1:0] {
        StIdle,
        StRound,
        StDone
    } state_e;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [KEY_W-1:0]   key_q, key_d;
    logic [15:0]        data_q, data_d;
    logic [15:0]        out_data_q, out_data_d;
    logic               out_valid_q, out_valid_d;
    logic               in_ready_q, in_ready_d;
    logic               busy_q, busy_d;

    logic [15:0]        rkey;
    logic [15:0]        round_t;

    function automatic logic [3:0] inv_sbox(input logic [3:0] x);
        logic [3:0] y;
        case (x)
            4'h0: y = 4'h9;
            4'h1: y = 4'h8;
            4'h2: y = 4'h3;
            4'h3: y = 4'h7;
            4'h4: y = 4'h6;
            4'h5: y = 4'h1;
            4'h6: y = 4'h4;
            4'h7: y = 4'hE;
            4'h8: y = 4'h2;
            4'h9: y = 4'hB;
            4'hA: y = 4'h0;
            4'hB: y = 4'hA;
            4'hC: y = 4'h5;
            4'hD: y = 4'hD;
            4'hE: y = 4'hF;
            default: y = 4'hC;
        endcase
        return y;
    endfunction

    function automatic logic [15:0] inv_sbox_word(input logic [15:0] x);
        logic [15:0] y;
        for (int n = 0; n < 4; n++) begin
            y[4*n +: 4] = inv_sbox(x[4*n +: 4]);
        end
        return y;
    endfunction

    // 4x4 bit transpose: bit b of nibble n <-> bit n of nibble b (self-inverse).
    function automatic logic [15:0] perm(input logic [15:0] x);
        logic [15:0] y;
        for (int n = 0; n < 4; n++) begin
            for (int b = 0; b < 4; b++) begin
                y[4*b + n] = x[4*n + b];
            end
        end
        return y;
    endfunction

    // Round cnt=i consumes K_(R-i), taken from the latched key only.
    always_comb begin
        rkey = '0;
        for (int unsigned r = 0; r <= ROUNDS; r++) begin
            if (cnt_q == CNT_W'(ROUNDS - r)) begin
                rkey = key_q[KEY_W-1-4*r -: 16];
            end
        end
        round_t = inv_sbox_word(data_q) ^ rkey;
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        key_d      = key_q;
        data_d     = data_q;
        out_data_d = out_data_q;

        unique case (state_q)
            StIdle: begin
                if (in_valid && in_ready_q) begin
                    key_d   = in_key;
                    data_d  = in_data ^ in_key[15:0];
                    cnt_d   = CNT_W'(1);
                    state_d = StRound;
                end
            end
            StRound: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(ROUNDS)) begin
                    data_d     = round_t;
                    out_data_d = round_t;
                    state_d    = StDone;
                end else begin
                    data_d = perm(round_t);
                end
            end
            StDone: begin
                if (out_ready) begin
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        in_ready_d  = (state_d == StIdle);
        busy_d      = (state_d != StIdle);
        out_valid_d = (state_d == StDone);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            key_q       <= '0;
            data_q      <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            key_q       <= key_d;
            data_q      <= data_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            in_ready_q  <= in_ready_d;
            busy_q      <= busy_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign busy      = busy_q;

endmodule
